// File: rtl/num_combiner.sv
// num_combiner: sequential BCD-to-binary combiner.
// Rebuilds tens*10 + ones by seeding the accumulator with the ones digit and
// adding 10 once per cycle while the captured tens count runs down to zero.
// Results above MAX, or requests with a non-BCD digit, report err with num=0.
//
// Handshake: start is a request strobe that is accepted only when the block
// is idle (busy=0) at a rising clock edge; requests seen while busy are
// dropped, never queued. Each accepted request produces exactly one
// single-cycle done pulse, and num/err change only on that pulse.
module num_combiner #(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [3:0] ten_in,
  input  logic [3:0] one_in,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [6:0] num,
  output logic       dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  localparam logic [6:0] MAX7 = 7'(MAX);

  state_t     state;
  state_t     state_nxt;
  logic [6:0] acc;
  logic [3:0] cnt;
  logic       digits_ok;
  logic       accept;

  assign digits_ok = (ten_in <= 4'd9) && (one_in <= 4'd9);
  assign accept    = (state == S_IDLE) && start;

  // State register; reset always returns to idle so an aborted request is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: enter CONV on a valid request, leave once the tens count is exhausted.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && digits_ok) state_nxt = S_CONV;
      S_CONV: if (cnt == 4'd0)        state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state: busy covers every CONV cycle.
  always_comb begin
    busy      = (state == S_CONV);
    dbg_state = state;
  end

  // Datapath: capture digits, accumulate tens, publish result with a done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc  <= 7'd0;
      cnt  <= 4'd0;
      done <= 1'b0;
      err  <= 1'b0;
      num  <= 7'd0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (digits_ok) begin
          acc <= {3'b000, one_in};
          cnt <= ten_in;
        end else begin
          num  <= 7'd0;
          err  <= 1'b1;
          done <= 1'b1;
        end
      end else if (state == S_CONV) begin
        if (cnt != 4'd0) begin
          // acc never exceeds 99 here, so 7 bits cannot overflow.
          acc <= acc + 7'd10;
          cnt <= cnt - 4'd1;
        end else begin
          done <= 1'b1;
          if (acc <= MAX7) begin
            num <= acc;
            err <= 1'b0;
          end else begin
            num <= 7'd0;
            err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_num_combiner.sv
// Testbench for num_combiner: two instances (MAX=59 and MAX=23) share all
// inputs; table-driven requests plus hand-written multi-cycle sequences.
module tb_num_combiner;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [3:0] ten_in;
  logic [3:0] one_in;

  logic       busy59, done59, err59, dbg59;
  logic [6:0] num59;
  logic       busy23, done23, err23, dbg23;
  logic [6:0] num23;

  int n_checks = 0;
  int n_fail   = 0;

  num_combiner #(.MAX(59)) dut59 (
    .clk(clk), .rstn(rstn), .start(start), .ten_in(ten_in), .one_in(one_in),
    .busy(busy59), .done(done59), .err(err59), .num(num59), .dbg_state(dbg59)
  );

  num_combiner #(.MAX(23)) dut23 (
    .clk(clk), .rstn(rstn), .start(start), .ten_in(ten_in), .one_in(one_in),
    .busy(busy23), .done(done23), .err(err23), .num(num23), .dbg_state(dbg23)
  );

  // Clock and global time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0] t;
    logic [3:0] o;
    logic [6:0] n59;
    logic       e59;
    logic [6:0] n23;
    logic       e23;
    int         lat;  // edges after the start edge until done; 0 for invalid digits
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait for done59 after the current sample point; returns edges waited (bounded).
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done59 && lat < 15) begin
      if (busy59) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done59) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 15 cycles");
    end
  endtask

  // Issue one request, scramble the digit inputs during conversion, check result.
  task automatic run_req(input vec_t v, input string tag);
    int lat;
    int bc;
    @(negedge clk);
    start  = 1'b1;
    ten_in = v.t;
    one_in = v.o;
    @(posedge clk); #1;
    start  = 1'b0;
    ten_in = 4'($urandom_range(0, 15));
    one_in = 4'($urandom_range(0, 15));
    wait_done(lat, bc);
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_busy_cycles"}, bc, v.lat);
    chk({tag, "_busy_at_done"}, int'(busy59), 0);
    chk({tag, "_num59"}, int'(num59), int'(v.n59));
    chk({tag, "_err59"}, int'(err59), int'(v.e59));
    chk({tag, "_done23"}, int'(done23), 1);
    chk({tag, "_num23"}, int'(num23), int'(v.n23));
    chk({tag, "_err23"}, int'(err23), int'(v.e23));
    @(posedge clk); #1;
    chk({tag, "_done_single"}, int'(done59), 0);
    chk({tag, "_num_held"}, int'(num59), int'(v.n59));
  endtask

  initial begin
    int lat;
    int bc;
    int seen;

    vecs[0]  = '{t: 4'd0, o: 4'd0,  n59: 7'd0,  e59: 1'b0, n23: 7'd0,  e23: 1'b0, lat: 1};
    vecs[1]  = '{t: 4'd5, o: 4'd9,  n59: 7'd59, e59: 1'b0, n23: 7'd0,  e23: 1'b1, lat: 6};
    vecs[2]  = '{t: 4'd6, o: 4'd0,  n59: 7'd0,  e59: 1'b1, n23: 7'd0,  e23: 1'b1, lat: 7};
    vecs[3]  = '{t: 4'd2, o: 4'd4,  n59: 7'd24, e59: 1'b0, n23: 7'd0,  e23: 1'b1, lat: 3};
    vecs[4]  = '{t: 4'd2, o: 4'd3,  n59: 7'd23, e59: 1'b0, n23: 7'd23, e23: 1'b0, lat: 3};
    vecs[5]  = '{t: 4'd3, o: 4'd12, n59: 7'd0,  e59: 1'b1, n23: 7'd0,  e23: 1'b1, lat: 0};
    vecs[6]  = '{t: 4'd1, o: 4'd7,  n59: 7'd17, e59: 1'b0, n23: 7'd17, e23: 1'b0, lat: 2};
    vecs[7]  = '{t: 4'd9, o: 4'd9,  n59: 7'd0,  e59: 1'b1, n23: 7'd0,  e23: 1'b1, lat: 10};
    vecs[8]  = '{t: 4'd0, o: 4'd9,  n59: 7'd9,  e59: 1'b0, n23: 7'd9,  e23: 1'b0, lat: 1};
    vecs[9]  = '{t: 4'd10, o: 4'd0, n59: 7'd0,  e59: 1'b1, n23: 7'd0,  e23: 1'b1, lat: 0};
    vecs[10] = '{t: 4'd4, o: 4'd2,  n59: 7'd42, e59: 1'b0, n23: 7'd0,  e23: 1'b1, lat: 5};

    // Reset
    rstn   = 1'b0;
    start  = 1'b0;
    ten_in = 4'd0;
    one_in = 4'd0;
    #12;
    chk("rst_busy", int'(busy59), 0);
    chk("rst_done", int'(done59), 0);
    chk("rst_err", int'(err59), 0);
    chk("rst_num", int'(num59), 0);
    chk("rst_state", int'(dbg59), 0);
    chk("rst_num23", int'(num23), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("idle_done", int'(done59), 0);

    // Table-driven requests
    for (int i = 0; i < 11; i++) begin
      run_req(vecs[i], $sformatf("vec%0d", i));
    end

    // Held result: no request for a few cycles, num/err stay put
    repeat (3) @(posedge clk);
    #1;
    chk("hold_num", int'(num59), 42);
    chk("hold_err", int'(err59), 0);

    // Back-to-back: start held high through CONV with other digits, re-sampled in done cycle
    @(negedge clk);
    start  = 1'b1;
    ten_in = 4'd4;
    one_in = 4'd2;
    @(posedge clk); #1;
    chk("b2b_state_conv", int'(dbg59), 1);
    ten_in = 4'd1;
    one_in = 4'd1;
    wait_done(lat, bc);
    chk("b2b_first_latency", lat, 5);
    chk("b2b_first_num", int'(num59), 42);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept_busy", int'(busy59), 1);
    chk("b2b_accept_nodone", int'(done59), 0);
    wait_done(lat, bc);
    chk("b2b_second_latency", lat, 2);
    chk("b2b_second_num", int'(num59), 11);
    chk("b2b_second_err", int'(err59), 0);
    chk("b2b_second_num23", int'(num23), 11);

    // Asynchronous reset mid-conversion
    @(negedge clk);
    start  = 1'b1;
    ten_in = 4'd5;
    one_in = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_busy", int'(busy59), 0);
    chk("arst_done", int'(done59), 0);
    chk("arst_num", int'(num59), 0);
    chk("arst_err", int'(err59), 0);
    chk("arst_state", int'(dbg59), 0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done59 || busy59) seen++;
    end
    chk("arst_no_done", seen, 0);
    run_req('{t: 4'd2, o: 4'd8, n59: 7'd28, e59: 1'b0, n23: 7'd0, e23: 1'b1, lat: 3}, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
